// File: rtl/madd_eval_pkg.sv
// Shared types and helpers for the multiply-add error-evaluation sweep.
// Holds the default operand widths, the sweep state encoding and the
// reference multiply-add used to produce exact results.
package madd_eval_pkg;

    localparam int A_W_DEF = 6;
    localparam int B_W_DEF = 6;
    localparam int C_W_DEF = 6;
    localparam int R_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Exact a*b+c on zero-extended operands; callers narrow to their result width
    function automatic logic [31:0] exact_madd(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [31:0] c);
        return (a * b) + c;
    endfunction

endpackage

// File: rtl/madd_err_acc.sv
// Error accumulator: aligns the exact result with the DUT output through a
// LAT-deep valid+result delay line, then tracks mismatch count, maximum
// absolute error and a saturating sum of absolute errors.
module madd_err_acc
    import madd_eval_pkg::*;
#(
    parameter int R_W   = R_W_DEF,
    parameter int LAT   = 0,
    parameter int SUM_W = 32,
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [R_W-1:0]   exact_i,
    input  logic [R_W-1:0]   approx_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [R_W-1:0]   max_o,
    output logic [SUM_W-1:0] sum_o
);

    localparam int ADD_W = ((SUM_W > R_W) ? SUM_W : R_W) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX     = {SUM_W{1'b1}};
    localparam logic [ADD_W-1:0] SUM_MAX_EXT = {{(ADD_W - SUM_W){1'b0}}, {SUM_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic             samp_valid_s;
    logic [R_W-1:0]   samp_exact_s;
    logic [R_W-1:0]   diff_s;
    logic [ADD_W-1:0] sum_ext_s;
    logic [SUM_W-1:0] sum_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [R_W-1:0]   max_r;
    logic [SUM_W-1:0] sum_r;

    generate
        if (LAT == 0) begin : g_nodelay
            assign samp_valid_s = valid_i;
            assign samp_exact_s = exact_i;
        end else begin : g_delay
            logic [LAT-1:0] dl_valid_r;
            logic [R_W-1:0] dl_exact_r [LAT];

            // Shift valid flag and exact result so they meet the DUT output
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl_valid_r <= {LAT{1'b0}};
                    for (int i = 0; i < LAT; i++) begin
                        dl_exact_r[i] <= {R_W{1'b0}};
                    end
                end else if (flush_i) begin
                    dl_valid_r <= {LAT{1'b0}};
                end else begin
                    dl_valid_r[0] <= valid_i;
                    dl_exact_r[0] <= exact_i;
                    for (int i = 1; i < LAT; i++) begin
                        dl_valid_r[i] <= dl_valid_r[i-1];
                        dl_exact_r[i] <= dl_exact_r[i-1];
                    end
                end
            end

            assign samp_valid_s = dl_valid_r[LAT-1];
            assign samp_exact_s = dl_exact_r[LAT-1];
        end
    endgenerate

    // Absolute error and saturating next value of the error sum
    always_comb begin
        diff_s     = {R_W{1'b0}};
        sum_ext_s  = {ADD_W{1'b0}};
        sum_next_s = {SUM_W{1'b0}};
        if (samp_exact_s >= approx_i) begin
            diff_s = samp_exact_s - approx_i;
        end else begin
            diff_s = approx_i - samp_exact_s;
        end
        sum_ext_s = ADD_W'(sum_r) + ADD_W'(diff_s);
        if (sum_ext_s > SUM_MAX_EXT) begin
            sum_next_s = SUM_MAX;
        end else begin
            sum_next_s = sum_ext_s[SUM_W-1:0];
        end
    end

    // Statistics registers: cleared on start, frozen while flushing (abort)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            max_r <= {R_W{1'b0}};
            sum_r <= {SUM_W{1'b0}};
        end else if (clear_i) begin
            cnt_r <= {CNT_W{1'b0}};
            max_r <= {R_W{1'b0}};
            sum_r <= {SUM_W{1'b0}};
        end else if (samp_valid_s && !flush_i) begin
            if (diff_s != {R_W{1'b0}}) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (diff_s > max_r) begin
                max_r <= diff_s;
            end
            sum_r <= sum_next_s;
        end
    end

    assign cnt_o = cnt_r;
    assign max_o = max_r;
    assign sum_o = sum_r;

endmodule

// File: rtl/madd_err_sweep_ctrl.sv
// Exhaustive sweep sequencer: steps every {c,b,a} vector into a multiply-add
// DUT, computes the exact result and hands both to the error accumulator.
module madd_err_sweep_ctrl
    import madd_eval_pkg::*;
#(
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int C_W     = C_W_DEF,
    parameter int R_W     = R_W_DEF,
    parameter int DUT_LAT = 0,
    parameter int SUM_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic [A_W+B_W+C_W-1:0] vec_o,
    output logic                   vec_valid_o,
    input  logic [R_W-1:0]         approx_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [A_W+B_W+C_W:0]   err_cnt_o,
    output logic [R_W-1:0]         max_err_o,
    output logic [SUM_W-1:0]       sum_err_o
);

    localparam int V_W  = A_W + B_W + C_W;
    localparam int DC_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [V_W-1:0]  LAST_VEC   = {V_W{1'b1}};
    localparam logic [V_W-1:0]  VEC_ONE    = {{(V_W - 1){1'b0}}, 1'b1};
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);
    localparam logic [DC_W-1:0] DC_ONE     = {{(DC_W - 1){1'b0}}, 1'b1};

    state_e          state_r;
    logic [V_W-1:0]  vec_r;
    logic            vec_valid_r;
    logic            busy_r;
    logic            done_r;
    logic [DC_W-1:0] drain_cnt_r;
    logic            start_ok_s;
    logic            flush_s;
    logic [R_W-1:0]  exact_s;

    // A start is accepted only from IDLE/DONE and never alongside an abort
    always_comb begin
        start_ok_s = 1'b0;
        if (((state_r == IDLE) || (state_r == DONE)) && start_i && !abort_i) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
        flush_s = abort_i | start_ok_s;
        exact_s = R_W'(exact_madd(32'(vec_r[A_W-1:0]),
                                  32'(vec_r[A_W+B_W-1:A_W]),
                                  32'(vec_r[V_W-1:A_W+B_W])));
    end

    // Sweep FSM with registered vector, valid, busy and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            vec_r       <= {V_W{1'b0}};
            vec_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            drain_cnt_r <= {DC_W{1'b0}};
        end else if (abort_i) begin
            state_r     <= IDLE;
            vec_r       <= {V_W{1'b0}};
            vec_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            drain_cnt_r <= {DC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        state_r     <= RUN;
                        vec_r       <= {V_W{1'b0}};
                        vec_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (vec_r == LAST_VEC) begin
                        vec_r       <= {V_W{1'b0}};
                        vec_valid_r <= 1'b0;
                        drain_cnt_r <= {DC_W{1'b0}};
                        if (DUT_LAT > 0) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        vec_r <= vec_r + VEC_ONE;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + DC_ONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    vec_r       <= {V_W{1'b0}};
                    vec_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    madd_err_acc #(
        .R_W   (R_W),
        .LAT   (DUT_LAT),
        .SUM_W (SUM_W),
        .CNT_W (V_W + 1)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (start_ok_s),
        .flush_i  (flush_s),
        .valid_i  (vec_valid_r),
        .exact_i  (exact_s),
        .approx_i (approx_i),
        .cnt_o    (err_cnt_o),
        .max_o    (max_err_o),
        .sum_o    (sum_err_o)
    );

    assign vec_o       = vec_r;
    assign vec_valid_o = vec_valid_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_madd_err_sweep_ctrl.sv
// Bench for madd_err_sweep_ctrl: two instances (combinational DUT with a wide
// sum, 2-cycle DUT with a narrow saturating sum) share start/abort. A table
// defines the DUT response per vector; expected statistics are computed
// directly from that table and checked by a monitor when busy_o falls.
module tb_madd_err_sweep_ctrl;

    localparam int A_W = 3, B_W = 3, C_W = 3, R_W = 7;
    localparam int V_W = A_W + B_W + C_W;
    localparam int N   = 1 << V_W;
    localparam int LAT0 = 0, SW0 = 32;
    localparam int LAT1 = 2, SW1 = 12;

    typedef struct {
        longint cnt;
        longint mx;
        longint sum;
        longint cyc;
        longint done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic [V_W-1:0] vec0, vec1, p1, p2;
    logic vv0, vv1, busy0, busy1, done0, done1;
    logic [R_W-1:0] apx0, apx1, max0, max1;
    logic [V_W:0] cnt0, cnt1;
    logic [SW0-1:0] sum0;
    logic [SW1-1:0] sum1;

    int tab [N];
    exp_t q0[$], q1[$];
    int checks = 0, failures = 0;

    int  bcnt [2];
    bit  bprev [2];
    int  eidx [2];
    bit  dchk [2];

    always #5 clk = ~clk;

    madd_err_sweep_ctrl #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .R_W(R_W), .DUT_LAT(LAT0), .SUM_W(SW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .vec_o(vec0), .vec_valid_o(vv0),
        .approx_i(apx0), .busy_o(busy0), .done_o(done0), .err_cnt_o(cnt0), .max_err_o(max0), .sum_err_o(sum0));

    madd_err_sweep_ctrl #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .R_W(R_W), .DUT_LAT(LAT1), .SUM_W(SW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .vec_o(vec1), .vec_valid_o(vv1),
        .approx_i(apx1), .busy_o(busy1), .done_o(done1), .err_cnt_o(cnt1), .max_err_o(max1), .sum_err_o(sum1));

    // Behavioural DUTs: table lookup, immediate for dut0 and two cycles late for dut1
    always @(posedge clk) begin
        p1 <= vec1;
        p2 <= p1;
    end
    assign apx0 = R_W'(tab[int'(vec0)]);
    assign apx1 = R_W'(tab[int'(p2)]);

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exact_of(input int v);
        int a, b, c;
        a = v % (1 << A_W);
        b = (v >> A_W) % (1 << B_W);
        c = v >> (A_W + B_W);
        return a * b + c;
    endfunction

    // Expected stats: samples of vectors v < k-lat survive an abort at index k
    function automatic exp_t model(input int lat, input int sw, input int k);
        exp_t e;
        longint s, lim;
        int m, d;
        e.cnt = 0; e.mx = 0; s = 0;
        m = (k < 0) ? N : ((k - lat > 0) ? k - lat : 0);
        for (int v = 0; v < m; v++) begin
            d = exact_of(v) - tab[v];
            if (d < 0) d = -d;
            if (d != 0) e.cnt++;
            if (d > e.mx) e.mx = d;
            s += d;
        end
        lim = (64'sd1 <<< sw) - 1;
        e.sum  = (s > lim) ? lim : s;
        e.cyc  = (k < 0) ? N + lat : k + 1;
        e.done = (k < 0) ? 1 : 0;
        return e;
    endfunction

    // Monitor: checks vector order and pops one expectation per busy fall
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                bcnt[d] = 0; bprev[d] = 1'b0; eidx[d] = 0; dchk[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic b, dn, vv;
                int vc;
                exp_t e;
                b  = (d == 0) ? busy0 : busy1;
                dn = (d == 0) ? done0 : done1;
                vv = (d == 0) ? vv0 : vv1;
                vc = (d == 0) ? int'(vec0) : int'(vec1);
                if (dchk[d]) begin
                    chk($sformatf("done_one_cycle[%0d]", d), longint'(dn), 0);
                    dchk[d] = 1'b0;
                end
                if (vv) begin
                    chk($sformatf("vec_order[%0d]", d), vc, eidx[d]);
                    eidx[d]++;
                end
                if (b) begin
                    bcnt[d]++;
                end else if (bprev[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk($sformatf("unexpected_end[%0d]", d), 1, 0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("err_cnt[%0d]", d), (d == 0) ? longint'(cnt0) : longint'(cnt1), e.cnt);
                        chk($sformatf("max_err[%0d]", d), (d == 0) ? longint'(max0) : longint'(max1), e.mx);
                        chk($sformatf("sum_err[%0d]", d), (d == 0) ? longint'(sum0) : longint'(sum1), e.sum);
                        chk($sformatf("busy_cycles[%0d]", d), bcnt[d], e.cyc);
                        chk($sformatf("done_pulse[%0d]", d), longint'(dn), e.done);
                    end
                    dchk[d] = 1'b1;
                    bcnt[d] = 0;
                    eidx[d] = 0;
                end
                bprev[d] = b;
            end
        end
    end

    task automatic fill_tab(input int mode);
        int ex, r;
        for (int v = 0; v < N; v++) begin
            ex = exact_of(v);
            case (mode)
                0: tab[v] = ex;
                1: tab[v] = 0;
                2: tab[v] = ex & ~1;
                3: begin
                    r = $urandom_range(0, 7);
                    if (r == 0) tab[v] = ex + 1;
                    else if (r == 1) tab[v] = (ex > 0) ? ex - 1 : ex + 1;
                    else if (r == 2) tab[v] = ex + $urandom_range(2, 5);
                    else tab[v] = ex;
                end
                4: tab[v] = $urandom_range(0, (1 << R_W) - 1);
                5: tab[v] = ex + 1;
                default: tab[v] = ex;
            endcase
        end
    endtask

    task automatic pulse(output logic sig_unused);
        sig_unused = 1'b0;
    endtask

    task automatic wait_vec(input int k, input string tag);
        bit found;
        found = 1'b0;
        for (int t = 0; t < N + 20 && !found; t++) begin
            @(negedge clk);
            if (vv0 && int'(vec0) == k) found = 1'b1;
        end
        if (!found) chk(tag, 0, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy0 || busy1) && t < N + 100) begin
            @(negedge clk);
            t++;
        end
        if (busy0 || busy1) chk("idle_timeout", 1, 0);
    endtask

    // One sweep: mode selects the DUT response, k>=0 aborts at vector k,
    // extra>=0 re-pulses start while that vector is on vec_o
    task automatic run(input int mode, input int k, input int extra);
        fill_tab(mode);
        q0.push_back(model(LAT0, SW0, k));
        q1.push_back(model(LAT1, SW1, k));
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (extra >= 0) begin
            wait_vec(extra, "extra_start_wait");
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (k >= 0) begin
            wait_vec(k, "abort_wait");
            abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q0.size() + q1.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_vec"},  longint'(vec0) + longint'(vec1), 0);
        chk({tag, "_ctl"},  longint'({vv0, vv1, busy0, busy1, done0, done1}), 0);
        chk({tag, "_cnt"},  longint'(cnt0) + longint'(cnt1), 0);
        chk({tag, "_max"},  longint'(max0) + longint'(max1), 0);
        chk({tag, "_sum"},  longint'(sum0) + longint'(sum1), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        fill_tab(0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, -1, 100);                          // loopback, ignored second start
        run(1, -1, -1);                           // tied to zero, dut1 saturates
        run(2, -1, -1);                           // bit0 cleared
        run(3, -1, 300);                          // sparse small errors
        run(4, -1, -1);                           // fully random responses
        run(5, $urandom_range(10, 480), -1);      // +1 error, abort mid-sweep
        run(3, -1, -1);                           // restart clears stats
        run(5, 1, -1);                            // abort right after start
        run(5, N - 1, -1);                        // abort on the last vector

        // Asynchronous reset in the middle of a sweep
        fill_tab(4);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_vec(200, "reset_wait");
        #2 rst_n = 1'b0;
        #1 check_zero("midrun_reset");
        repeat (2) @(negedge clk);
        check_zero("held_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", longint'({busy0, busy1, vv0, vv1}), 0);

        run(4, -1, -1);                           // full sweep after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
